// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide: one product or quotient bit per cycle,
// start/ready handshake, busy for pipeline stall, flush to abort.
//
//   state  | meaning
//   IDLE   | waiting for ctrl_MULT / ctrl_DIV
//   MUL    | shift-add steps on operand magnitudes
//   DIV    | restoring-division steps on operand magnitudes
//   DONE   | result registered, data_resultRDY high for this cycle
module multdiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] operand_A,
    input  logic [WIDTH-1:0] operand_B,
    input  logic             flush,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               exc_q, exc_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     add_sum, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_s;
    logic [WIDTH:0]     mul_top;
    logic               mul_ovf, div_ovf, last_step;
    logic [WIDTH-1:0]   quot, quot_s;

    assign mag_a = operand_A[WIDTH-1] ? -operand_A : operand_A;
    assign mag_b = operand_B[WIDTH-1] ? -operand_B : operand_B;

    // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
    assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {add_sum, acc_q[WIDTH-1:1]};
    assign prod_s   = sign_q ? -mul_next : mul_next;
    assign mul_top  = prod_s[2*WIDTH-1:WIDTH-1];
    assign mul_ovf  = !((&mul_top) || !(|mul_top));

    // Divide: remainder in the high half, dividend/quotient bits in the low half.
    assign div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
    assign div_next = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign quot     = div_next[WIDTH-1:0];
    assign quot_s   = sign_q ? -quot : quot;
    // Magnitude quotient never exceeds 2^(W-1); only MIN / -1 lands there unsigned.
    assign div_ovf  = !sign_q && quot[WIDTH-1];

    assign last_step = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        sign_d  = sign_q;
        res_d   = res_q;
        exc_d   = exc_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    state_d = S_IDLE;
                    if (ctrl_MULT || ctrl_DIV) begin
                        sign_d = operand_A[WIDTH-1] ^ operand_B[WIDTH-1];
                        cnt_d  = '0;
                        if (ctrl_MULT) begin
                            state_d = S_MUL;
                            acc_d   = {{WIDTH{1'b0}}, mag_b};
                            opb_d   = mag_a;
                        end else if (operand_B == '0) begin
                            state_d = S_DONE;
                            res_d   = '0;
                            exc_d   = 1'b1;
                        end else begin
                            state_d = S_DIV;
                            acc_d   = {{WIDTH{1'b0}}, mag_a};
                            opb_d   = mag_b;
                        end
                    end
                end
                S_MUL: begin
                    acc_d = mul_next;
                    cnt_d = cnt_q + CW'(1);
                    if (last_step) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                        res_d   = prod_s[WIDTH-1:0];
                        exc_d   = mul_ovf;
                    end
                end
                S_DIV: begin
                    acc_d = div_next;
                    cnt_d = cnt_q + CW'(1);
                    if (last_step) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                        res_d   = quot_s;
                        exc_d   = div_ovf;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            sign_q  <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            sign_q  <= sign_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == S_DONE);
    assign busy           = (state_q == S_MUL) || (state_q == S_DIV);

endmodule
